// File: rtl/alu_pkg.sv
// Shared ALU definitions for the EX stage.
//   ALU_* : ALUControl encodings produced by the ALU decoder.
//   bitcnt_state_e : state encoding of the bit-count sequencer.
//   op_is_bitcnt() : true for the Zbb bit-count ops (CLZ, CTZ, CPOP).
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_CTZ  = 4'b0110;
  localparam logic [3:0] ALU_CLZ  = 4'b0111;
  localparam logic [3:0] ALU_CPOP = 4'b1000;

  // Count width: holds 0..32.
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bitcnt_state_e;

  function automatic logic op_is_bitcnt(input logic [3:0] op);
    return (op == ALU_CLZ) || (op == ALU_CTZ) || (op == ALU_CPOP);
  endfunction

endpackage

// File: rtl/bitcnt_chunk.sv
// Combinational per-beat counter for one CHUNK-bit slice.
//   slice    : bits examined this beat
//   op       : ALUControl of the running op; ALU_CLZ scans MSB first,
//              anything else scans LSB first
//   zero_run : zeros before the first 1 in scan order (CHUNK if none)
//   has_one  : slice contains at least one 1
//   pop      : number of 1s in the slice
module bitcnt_chunk
  import alu_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] slice,
  input  logic [3:0]       op,
  output logic [CNT_W-1:0] zero_run,
  output logic             has_one,
  output logic [CNT_W-1:0] pop
);

  logic hit;
  logic bit_in_order;

  always_comb begin
    zero_run     = '0;
    pop          = '0;
    hit          = 1'b0;
    bit_in_order = 1'b0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      bit_in_order = (op == ALU_CLZ) ? slice[CHUNK-1-i] : slice[i];
      if (!hit) begin
        if (bit_in_order) hit = 1'b1;
        else              zero_run = zero_run + 1'b1;
      end
      pop = pop + CNT_W'(slice[i]);
    end
    has_one = |slice;
  end

endmodule

// File: rtl/bitcnt_seq.sv
// Multi-cycle CLZ / CTZ / CPOP sequencer beside the EX-stage ALU.
// Scans CHUNK bits per cycle over XLEN/CHUNK RUN beats and stalls the
// pipeline until the count is ready.
//   clk, reset : clock, synchronous active-high reset
//   start      : EX holds a valid instruction
//   ALUControl : decoder op; only CLZ/CTZ/CPOP start the sequencer
//   src        : rs1 operand, sampled on the accepting edge
//   flush      : EX flush; aborts a running op
//   stall      : combinational hold of IF/ID/EX
//   done       : one-cycle pulse, result valid
//   result     : count zero-extended to XLEN, held until the next done
module bitcnt_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] src,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned N  = XLEN / CHUNK;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  bitcnt_state_e    state;
  logic [XLEN-1:0]  sh;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] count;
  logic             found;
  logic [BW-1:0]    beat;

  logic             accept;
  logic [CHUNK-1:0] slice;
  logic [CNT_W-1:0] zero_run;
  logic [CNT_W-1:0] pop;
  logic             has_one;
  logic [CNT_W-1:0] count_next;
  logic             found_next;
  logic [XLEN-1:0]  sh_next;

  assign accept = (state == IDLE) && start && op_is_bitcnt(ALUControl) && !flush;
  assign stall  = accept || (state == RUN);

  // CLZ consumes from the top and shifts left; CTZ/CPOP consume from the bottom.
  assign slice   = (op_q == ALU_CLZ) ? sh[XLEN-1 -: CHUNK] : sh[CHUNK-1:0];
  assign sh_next = (op_q == ALU_CLZ) ? (sh << CHUNK) : (sh >> CHUNK);

  bitcnt_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .slice    (slice),
    .op       (op_q),
    .zero_run (zero_run),
    .has_one  (has_one),
    .pop      (pop)
  );

  always_comb begin
    count_next = count;
    found_next = found;
    if (op_q == ALU_CPOP) begin
      count_next = count + pop;
    end else if (!found) begin
      count_next = count + zero_run;
      found_next = has_one;
    end
  end

  // result/done are registered on the last beat so both are valid in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sh     <= '0;
      op_q   <= '0;
      count  <= '0;
      found  <= 1'b0;
      beat   <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            sh    <= src;
            op_q  <= ALUControl;
            count <= '0;
            found <= 1'b0;
            beat  <= '0;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            sh    <= sh_next;
            count <= count_next;
            found <= found_next;
            beat  <= beat + 1'b1;
            if (beat == BW'(N - 1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= XLEN'(count_next);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcnt_seq.sv
// Self-checking bench for bitcnt_seq at CHUNK=4, 1 and 8.
// All three instances share stimulus; each step checks only the targeted one.
module tb_bitcnt_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [3:0]  ALUControl;
  logic [31:0] src;
  logic        stall_a [3];
  logic        done_a  [3];
  logic [31:0] res_a   [3];

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  bitcnt_seq #(.XLEN(32), .CHUNK(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl), .src(src),
    .flush(flush), .stall(stall_a[0]), .done(done_a[0]), .result(res_a[0]));
  bitcnt_seq #(.XLEN(32), .CHUNK(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl), .src(src),
    .flush(flush), .stall(stall_a[1]), .done(done_a[1]), .result(res_a[1]));
  bitcnt_seq #(.XLEN(32), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl), .src(src),
    .flush(flush), .stall(stall_a[2]), .done(done_a[2]), .result(res_a[2]));

  function automatic int unsigned nbeats(input int sel);
    case (sel)
      0:       return 8;
      1:       return 32;
      default: return 4;
    endcase
  endfunction

  // Bit-serial reference model.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] v);
    int unsigned n = 0;
    bit hit = 1'b0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (op == ALU_CPOP) n += v[k];
      else if (op == ALU_CLZ) begin
        if (!hit && v[31-k]) hit = 1'b1;
        else if (!hit) n++;
      end else begin
        if (!hit && v[k]) hit = 1'b1;
        else if (!hit) n++;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle, checks stall/done through the fixed
  // latency, then checks the result against the scoreboard.
  task automatic run_op(input int sel, input logic [3:0] op, input logic [31:0] v,
                        input bit poke_done);
    int unsigned n = nbeats(sel);
    logic [31:0] e;
    sb.push_back(model(op, v));
    start = 1'b1; ALUControl = op; src = v; flush = 1'b0;
    #1;
    chk($sformatf("stall_c0_s%0d", sel), 32'(stall_a[sel]), 32'd1);
    tick();
    start = 1'b0; src = $urandom; ALUControl = 4'($urandom_range(15));
    for (int unsigned c = 1; c <= n; c++) begin
      #1;
      chk($sformatf("stall_run_s%0d_c%0d", sel, c), 32'(stall_a[sel]), 32'd1);
      chk($sformatf("done_run_s%0d_c%0d", sel, c), 32'(done_a[sel]), 32'd0);
      tick();
    end
    #1;
    e = sb.pop_front();
    chk($sformatf("done_pulse_s%0d", sel), 32'(done_a[sel]), 32'd1);
    chk($sformatf("stall_done_s%0d", sel), 32'(stall_a[sel]), 32'd0);
    chk($sformatf("result_s%0d_op%0h_v%0h", sel, op, v), res_a[sel], e);
    if (poke_done) begin
      start = 1'b1; ALUControl = ALU_CLZ; flush = 1'b1;
      #1;
      chk("stall_done_poke", 32'(stall_a[sel]), 32'd0);
    end
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    chk($sformatf("done_after_s%0d", sel), 32'(done_a[sel]), 32'd0);
    chk($sformatf("stall_after_s%0d", sel), 32'(stall_a[sel]), 32'd0);
    chk($sformatf("result_hold_s%0d", sel), res_a[sel], e);
    last_res = e;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; ALUControl = ALU_ADD; src = '0;
    tick(); tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_stall_s%0d", s), 32'(stall_a[s]), 32'd0);
      chk($sformatf("rst_done_s%0d", s), 32'(done_a[s]), 32'd0);
      chk($sformatf("rst_result_s%0d", s), res_a[s], 32'd0);
    end
    reset = 1'b0;

    // Directed ops on CHUNK=4
    run_op(0, ALU_CLZ,  32'h0001_0000, 1'b0);
    run_op(0, ALU_CTZ,  32'h8000_0000, 1'b0);
    run_op(0, ALU_CTZ,  32'h0000_0000, 1'b0);
    run_op(0, ALU_CLZ,  32'h0000_0000, 1'b0);
    run_op(0, ALU_CPOP, 32'hF0F0_0F01, 1'b0);
    run_op(0, ALU_CPOP, 32'hFFFF_FFFF, 1'b0);
    run_op(0, ALU_CLZ,  32'hFFFF_FFFF, 1'b0);
    run_op(0, ALU_CTZ,  32'hFFFF_FFFF, 1'b1);

    // Flush in RUN cycle 4: back to IDLE, no done, result unchanged
    start = 1'b1; ALUControl = ALU_CLZ; src = 32'h0000_0001;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    #1;
    chk("flush_stall_c4", 32'(stall_a[0]), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_stall_idle", 32'(stall_a[0]), 32'd0);
    for (int c = 0; c < 10; c++) begin
      chk("flush_no_done", 32'(done_a[0]), 32'd0);
      chk("flush_result_kept", res_a[0], last_res);
      tick();
    end
    run_op(0, ALU_CLZ, 32'h8000_0000, 1'b0);

    // Non-bitcount start and start+flush are ignored
    start = 1'b1; ALUControl = ALU_ADD; src = 32'h1234_5678;
    #1;
    chk("add_stall", 32'(stall_a[0]), 32'd0);
    tick();
    ALUControl = ALU_CLZ; flush = 1'b1;
    #1;
    chk("startflush_stall", 32'(stall_a[0]), 32'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("ignored_stall", 32'(stall_a[0]), 32'd0);
      chk("ignored_done", 32'(done_a[0]), 32'd0);
      tick();
    end

    // Back-to-back on CHUNK=4
    run_op(0, ALU_CPOP, 32'h0000_0007, 1'b0);
    run_op(0, ALU_CTZ,  32'h0000_0008, 1'b0);

    // Reset mid-RUN clears everything on the next edge
    start = 1'b1; ALUControl = ALU_CPOP; src = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("midrst_stall", 32'(stall_a[0]), 32'd0);
    chk("midrst_done", 32'(done_a[0]), 32'd0);
    chk("midrst_result", res_a[0], 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("midrst_no_done", 32'(done_a[0]), 32'd0);
      tick();
    end

    // Back-to-back on CHUNK=1 and CHUNK=8
    run_op(1, ALU_CPOP, 32'h0000_0007, 1'b0);
    run_op(1, ALU_CTZ,  32'h0000_0008, 1'b0);
    run_op(1, ALU_CLZ,  32'h0001_0000, 1'b0);
    run_op(2, ALU_CPOP, 32'h0000_0007, 1'b0);
    run_op(2, ALU_CTZ,  32'h0000_0008, 1'b0);
    run_op(2, ALU_CLZ,  32'h0000_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
